uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_pkg.sv | 16 +
 rtl/uart_tx_fifo_if.sv | 29 ++
 rtl/uart_tx_fifo_mem.sv | 57 +++++
 rtl/uart_tx_fifo.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter with its transmit FIFO:
// the frame FSM state encoding and the line levels of the framing bits.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Bundle of the parallel write side, frame configuration and serial/status
// outputs of the UART transmitter. The master side is whoever feeds words
// in; the slave side is the transmitter itself.
interface uart_tx_fifo_if #(
    parameter int DATA_SIZE  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PRESCALE_W = 8
);
    logic [DATA_SIZE-1:0]            P_DATA;
    logic                            Data_Valid;
    logic                            Ready;
    logic                            PAR_EN;
    logic                            PAR_TYP;
    logic                            STOP2;
    logic [PRESCALE_W-1:0]           Prescale;
    logic                            TX_OUT;
    logic                            Busy;
    logic [$clog2(FIFO_DEPTH):0]     FIFO_LEVEL;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP, STOP2, Prescale,
        input  Ready, TX_OUT, Busy, FIFO_LEVEL
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, STOP2, Prescale,
        output Ready, TX_OUT, Busy, FIFO_LEVEL
    );
endinterface

// File: rtl/uart_tx_fifo_mem.sv
// Synchronous FIFO holding words waiting to be transmitted. Pointers carry
// one extra wrap bit so full and empty can be told apart; the storage array
// itself is never cleared, only the pointers are.
module uart_tx_fifo_mem #(
    parameter int DATA_SIZE  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [DATA_SIZE-1:0]          wr_data,
    input  logic                          rd_en,
    output logic [DATA_SIZE-1:0]          rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          full,
    output logic                          empty
);
    localparam int ADDR_W = $clog2(FIFO_DEPTH);

    logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
    logic [ADDR_W:0]      wr_ptr;
    logic [ADDR_W:0]      rd_ptr;
    logic                 do_write;
    logic                 do_read;

    assign do_write = wr_en && !full;
    assign do_read  = rd_en && !empty;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[ADDR_W-1:0]];

    // Advance the pointers on accepted writes and reads; both may happen together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_read) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage write; deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed from a small FIFO. Each popped word is latched
// together with its framing options so the frame on the line is immune to
// input changes once it has started. Frames run back to back while words
// remain queued.
module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int DATA_SIZE  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic          CLK,
    input  logic          RST,
    uart_tx_fifo_if.slave bus
);
    localparam int IDX_W = $clog2(DATA_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_SIZE - 1);

    tx_state_t               state;
    tx_state_t               next_state;
    logic [PRESCALE_W-1:0]   timer;
    logic [PRESCALE_W-1:0]   next_timer;
    logic [IDX_W-1:0]        bit_idx;
    logic [IDX_W-1:0]        next_idx;
    logic                    tx_reg;
    logic                    next_tx;
    logic                    busy_reg;
    logic                    pop;
    logic                    bit_done;
    logic                    parity_bit;

    logic [DATA_SIZE-1:0]    frame_word;
    logic                    frame_par_en;
    logic                    frame_par_typ;
    logic                    frame_stop2;
    logic [PRESCALE_W-1:0]   frame_prescale;

    logic [DATA_SIZE-1:0]    fifo_rd_data;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    fifo_wr;

    assign fifo_wr        = bus.Data_Valid && bus.Ready;
    assign bus.Ready      = !fifo_full;
    assign bus.TX_OUT     = tx_reg;
    assign bus.Busy       = busy_reg;

    uart_tx_fifo_mem #(
        .DATA_SIZE  (DATA_SIZE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RST),
        .wr_en   (fifo_wr),
        .wr_data (bus.P_DATA),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .level   (bus.FIFO_LEVEL),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign bit_done   = (timer == frame_prescale - 1'b1);
    assign parity_bit = (^frame_word) ^ frame_par_typ;

    // Capture the popped word and its framing options for the whole frame.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            frame_word     <= '0;
            frame_par_en   <= 1'b0;
            frame_par_typ  <= 1'b0;
            frame_stop2    <= 1'b0;
            frame_prescale <= PRESCALE_W'(1);
        end else if (pop) begin
            frame_word     <= fifo_rd_data;
            frame_par_en   <= bus.PAR_EN;
            frame_par_typ  <= bus.PAR_TYP;
            frame_stop2    <= bus.STOP2;
            frame_prescale <= (bus.Prescale == '0) ? PRESCALE_W'(1) : bus.Prescale;
        end
    end

    // State, bit timer, bit index and registered line/busy outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            timer    <= '0;
            bit_idx  <= '0;
            tx_reg   <= STOP_BIT;
            busy_reg <= 1'b0;
        end else begin
            state    <= next_state;
            timer    <= next_timer;
            bit_idx  <= next_idx;
            tx_reg   <= next_tx;
            busy_reg <= (next_state != IDLE);
        end
    end

    // Frame sequencing: move on when the current bit has lasted its full period.
    always_comb begin
        next_state = state;
        next_idx   = bit_idx;
        next_timer = (state == IDLE) ? '0 : timer + 1'b1;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = START;
                    next_timer = '0;
                end
            end
            START: begin
                if (bit_done) begin
                    next_state = DATA;
                    next_idx   = '0;
                    next_timer = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    next_timer = '0;
                    if (bit_idx == LAST_IDX) begin
                        next_idx   = '0;
                        next_state = frame_par_en ? PARITY : STOP;
                    end else begin
                        next_idx = bit_idx + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    next_state = STOP;
                    next_idx   = '0;
                    next_timer = '0;
                end
            end
            STOP: begin
                if (bit_done) begin
                    next_timer = '0;
                    if (frame_stop2 && (bit_idx == '0)) begin
                        next_idx = IDX_W'(1);
                    end else if (!fifo_empty) begin
                        pop        = 1'b1;
                        next_state = START;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: begin
                next_state = IDLE;
                next_timer = '0;
            end
        endcase
    end

    // Line level for the cycle after the edge, chosen from the bit being entered.
    always_comb begin
        next_tx = STOP_BIT;
        case (next_state)
            START:   next_tx = START_BIT;
            DATA:    next_tx = frame_word[next_idx];
            PARITY:  next_tx = parity_bit;
            default: next_tx = STOP_BIT;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: a frame-level model decides when words
// are accepted and popped, pushes the expected serial frame into a queue,
// and a negedge monitor compares the line cycle by cycle.
module tb_uart_tx_fifo;

    localparam int DS    = 8;
    localparam int DEPTH = 4;
    localparam int PW    = 8;

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        int          p;
    } frame_t;

    logic clk;
    logic rst_n;

    int total = 0;
    int bad   = 0;

    logic [DS-1:0] mq[$];
    frame_t        exp_q[$];
    int            rem = 0;
    int            lvl_pre;
    frame_t        cur;
    bit            in_frame = 0;
    int            cyc = 0;
    int            busy_cycles = 0;

    uart_tx_fifo_if #(.DATA_SIZE(DS), .FIFO_DEPTH(DEPTH), .PRESCALE_W(PW)) bus ();

    uart_tx_fifo #(
        .DATA_SIZE  (DS),
        .FIFO_DEPTH (DEPTH),
        .PRESCALE_W (PW)
    ) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic frame_t build_frame(input logic [DS-1:0] w, input logic pe,
                                           input logic pt, input logic s2,
                                           input logic [PW-1:0] ps);
        frame_t f;
        int n = 0;
        f.bits = '1;
        f.bits[n] = 1'b0;
        n++;
        for (int i = 0; i < DS; i++) begin
            f.bits[n] = w[i];
            n++;
        end
        if (pe) begin
            f.bits[n] = (^w) ^ pt;
            n++;
        end
        f.bits[n] = 1'b1;
        n++;
        if (s2) begin
            f.bits[n] = 1'b1;
            n++;
        end
        f.nbits = n;
        f.p = (ps == 0) ? 1 : int'(ps);
        return f;
    endfunction

    // Reference model: one frame occupies nbits*p cycles; the next queued word
    // is taken the edge after the previous frame ends, and writes are accepted
    // while the queue holds fewer than DEPTH words.
    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            rem = 0;
        end else begin
            lvl_pre = mq.size();
            if (rem > 0) begin
                rem--;
            end else if (mq.size() > 0) begin
                frame_t f;
                f = build_frame(mq.pop_front(), bus.PAR_EN, bus.PAR_TYP, bus.STOP2, bus.Prescale);
                exp_q.push_back(f);
                rem = f.nbits * f.p - 1;
            end
            if (bus.Data_Valid && (lvl_pre < DEPTH)) begin
                mq.push_back(bus.P_DATA);
            end
        end
    end

    // Monitor: pops an expected frame when one is due and checks each line cycle.
    always @(negedge clk) begin
        if (bus.Busy) busy_cycles++;
        if (!rst_n) begin
            in_frame = 0;
            exp_q.delete();
            checkOutput("rst_tx", bus.TX_OUT, 1);
            checkOutput("rst_busy", bus.Busy, 0);
            checkOutput("rst_level", bus.FIFO_LEVEL, 0);
            checkOutput("rst_ready", bus.Ready, 1);
        end else begin
            if (!in_frame && exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                in_frame = 1;
                cyc = 0;
            end
            if (in_frame) begin
                checkOutput("frame_bit", bus.TX_OUT, cur.bits[cyc / cur.p]);
                checkOutput("frame_busy", bus.Busy, 1);
                cyc++;
                if (cyc == cur.nbits * cur.p) in_frame = 0;
            end else begin
                checkOutput("idle_tx", bus.TX_OUT, 1);
                checkOutput("idle_busy", bus.Busy, 0);
            end
            checkOutput("level", bus.FIFO_LEVEL, mq.size());
            checkOutput("ready", bus.Ready, (mq.size() < DEPTH) ? 1 : 0);
        end
    end

    task automatic applyStimulus(input logic dv, input logic [DS-1:0] data);
        bus.Data_Valid = dv;
        bus.P_DATA     = data;
        @(posedge clk);
        #1;
        bus.Data_Valid = 1'b0;
    endtask

    task automatic setConfig(input logic pe, input logic pt, input logic s2, input logic [PW-1:0] ps);
        bus.PAR_EN   = pe;
        bus.PAR_TYP  = pt;
        bus.STOP2    = s2;
        bus.Prescale = ps;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitIdle(input int limit);
        int n = 0;
        while (!(mq.size() == 0 && rem == 0 && exp_q.size() == 0 && !in_frame) && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= limit) begin
            total++;
            bad++;
            $display("[TB] FAIL idle_timeout waited=%0d limit=%0d", n, limit);
        end
        idleCycles(2);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.Data_Valid = 1'b0;
        bus.P_DATA = '0;
        setConfig(1'b0, 1'b0, 1'b0, 8'd1);
        idleCycles(3);
        checkOutput("reset_tx", bus.TX_OUT, 1);
        checkOutput("reset_level", bus.FIFO_LEVEL, 0);
        rst_n = 1'b1;
        idleCycles(3);

        // 0xA5, even parity, one stop bit, 4 cycles per bit
        setConfig(1'b1, 1'b0, 1'b0, 8'd4);
        busy_cycles = 0;
        applyStimulus(1'b1, 8'hA5);
        @(posedge clk);
        #1;
        checkOutput("latency_a5", bus.TX_OUT, 0);
        waitIdle(200);
        checkOutput("busy_a5", busy_cycles, 44);

        // 0x01, odd parity, two stop bits: 12 bits at 3 cycles
        setConfig(1'b1, 1'b1, 1'b1, 8'd3);
        busy_cycles = 0;
        applyStimulus(1'b1, 8'h01);
        waitIdle(200);
        checkOutput("busy_odd_2stop", busy_cycles, 36);

        // Prescale 0 acts as 1: 10-cycle frame
        setConfig(1'b0, 1'b0, 1'b0, 8'd0);
        busy_cycles = 0;
        applyStimulus(1'b1, 8'h3C);
        @(posedge clk);
        #1;
        checkOutput("latency_3c", bus.TX_OUT, 0);
        waitIdle(100);
        checkOutput("busy_presc0", busy_cycles, 10);

        // Six consecutive writes into a 4-deep FIFO: sixth is dropped
        setConfig(1'b0, 1'b0, 1'b0, 8'd2);
        busy_cycles = 0;
        for (int i = 1; i <= 6; i++) applyStimulus(1'b1, DS'(i * 17));
        checkOutput("full_level", bus.FIFO_LEVEL, 4);
        checkOutput("full_ready", bus.Ready, 0);
        waitIdle(400);
        checkOutput("busy_five_frames", busy_cycles, 100);

        // Reset in the middle of frame 1 with two words queued
        setConfig(1'b0, 1'b0, 1'b0, 8'd4);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, DS'(8'h90 + i));
        idleCycles(12);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_tx", bus.TX_OUT, 1);
        checkOutput("abort_busy", bus.Busy, 0);
        checkOutput("abort_level", bus.FIFO_LEVEL, 0);
        idleCycles(3);
        rst_n = 1'b1;
        busy_cycles = 0;
        idleCycles(40);
        checkOutput("no_frame_after_reset", busy_cycles, 0);

        // Config change mid-frame only affects the next frame
        setConfig(1'b1, 1'b0, 1'b0, 8'd4);
        busy_cycles = 0;
        applyStimulus(1'b1, 8'h5A);
        applyStimulus(1'b1, 8'hC3);
        idleCycles(8);
        setConfig(1'b1, 1'b1, 1'b0, 8'd2);
        waitIdle(300);
        checkOutput("busy_cfg_change", busy_cycles, 66);

        // Randomised traffic with occasional configuration changes
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                setConfig(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), PW'($urandom_range(0, 3)));
            end
            applyStimulus(($urandom_range(0, 3) == 0), DS'($urandom));
        end
        waitIdle(3000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
